spram_arbiter: RTL

//  - Two-port round-robin arbiter/sequencer that shares one single-port RAM (SPRAM: cs/wr/rd, bidirectional data) between two requesters.
//  - Converts per-requester valid/ready request + response-valid handshakes into legal SPRAM cycles; owns tristate control of the RAM data bus.
//  - Sits between the SPRAM instance and two client blocks (e.g. a producer DMA and a consumer engine).

---
 rtl/spram_arb_pkg.sv | 15 +
 rtl/spram_arbiter_rr_arb2.sv | 36 +++
 rtl/spram_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/spram_arb_pkg.sv
// Shared definitions for the two-requester SPRAM arbiter: requester count and
// sequencer state encoding.
package spram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_DATA  = 3'd3,
        RSP      = 3'd4
    } arb_state_e;

endpackage

// File: rtl/spram_arbiter_rr_arb2.sv
// Two-way round-robin grant. The pointer names the preferred requester and
// flips to the loser only when a grant is actually accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       gnt_idx
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_idx = 1'b0;
        case (req)
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ptr_q;
            default: gnt_idx = 1'b0;
        endcase
        grant = 2'b00;
        if (req != 2'b00) begin
            grant = gnt_idx ? 2'b10 : 2'b01;
        end
        ptr_d = accept ? ~gnt_idx : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM between two valid/ready requesters. Ops are fully
// serialised; all RAM controls come straight from flops decoded from next state.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int AddrWidth = 4,
    parameter int DataWidth = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [NUM_REQ*AddrWidth-1:0]   req_addr,
    input  logic [NUM_REQ*DataWidth-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DataWidth-1:0]           rsp_rdata,
    output logic [AddrWidth-1:0]           ram_addr,
    inout  wire  [DataWidth-1:0]           ram_data,
    output logic                           ram_cs,
    output logic                           ram_wr,
    output logic                           ram_rd
);

    arb_state_e state_q, state_d;

    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 gnt_q, gnt_d;
    logic                 ram_cs_q, ram_cs_d;
    logic                 ram_wr_q, ram_wr_d;
    logic                 ram_rd_q, ram_rd_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0] grant;
    logic               gnt_idx;
    logic               accept;

    // Ready only in IDLE; gated by reset so nothing is accepted while held.
    assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .accept  (accept),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        gnt_d       = gnt_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    gnt_d   = gnt_idx;
                    addr_d  = req_addr[gnt_idx*AddrWidth +: AddrWidth];
                    wdata_d = req_wdata[gnt_idx*DataWidth +: DataWidth];
                    state_d = req_wr[gnt_idx] ? WRITE : RD_ISSUE;
                end
            end
            WRITE:    state_d = IDLE;
            RD_ISSUE: state_d = RD_DATA;
            RD_DATA: begin
                rsp_rdata_d = ram_data;
                state_d     = RSP;
            end
            RSP:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        ram_cs_d    = (state_d == WRITE) || (state_d == RD_ISSUE) || (state_d == RD_DATA);
        ram_wr_d    = (state_d == WRITE);
        ram_rd_d    = (state_d == RD_DATA);
        rsp_valid_d = '0;
        if (state_d == RSP) begin
            rsp_valid_d = gnt_d ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            gnt_q       <= 1'b0;
            ram_cs_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_rd_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gnt_q       <= gnt_d;
            ram_cs_q    <= ram_cs_d;
            ram_wr_q    <= ram_wr_d;
            ram_rd_q    <= ram_rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Bus is driven only during the write strobe, so it can never overlap ram_rd.
    assign ram_data  = ram_wr_q ? wdata_q : {DataWidth{1'bz}};
    assign ram_addr  = addr_q;
    assign ram_cs    = ram_cs_q;
    assign ram_wr    = ram_wr_q;
    assign ram_rd    = ram_rd_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
